// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Index vectors are sized for the largest legal requester count (8),
// so the same package serves every N_REQ instance without parameters.
package uart_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int N_REQ_MAX = 8;
    localparam int IDX_W     = $clog2(N_REQ_MAX);

    // One-hot (zero-extended to N_REQ_MAX) to binary index; 0 for an all-zero vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ_MAX; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Binary index to one-hot of N_REQ_MAX bits.
    function automatic logic [N_REQ_MAX-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first valid requester strictly after
// i_rr_ptr (wrapping) wins. i_rr_ptr must be below N_REQ.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int w_best;
    int w_sel;
    int w_dist;

    // Find the valid requester with the smallest distance past the pointer.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_best   = N_REQ;
        w_sel    = 0;
        w_dist   = 0;
        o_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            // NOTE: blocking '=' here because the loop must see its own earlier updates.
            w_dist = (j + 2 * N_REQ - int'(i_rr_ptr) - 1) % N_REQ;
            if (i_valid[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = j;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (o_any && (j == w_sel)) o_onehot[j] = 1'b1;
        end
    end

    assign o_any = |i_valid;
    assign o_idx = onehot_to_idx(N_REQ_MAX'(o_onehot));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX write port among
// N_REQ byte-stream requesters. A grant lasts until the byte flagged
// req_last is accepted, so packets never interleave.
// Optional feature: define UART_ARB_TIMEOUT_EN to release a lock whose owner
// has left req_valid low for TIMEOUT cycles (timeout_abort pulses once).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wr_uart,
    output logic [DATA_W-1:0]       w_data,
    input  logic                    tx_full,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_abort
);

    if ((N_REQ < 2) || (N_REQ > N_REQ_MAX) || (TIMEOUT < 2)) begin : g_bad_param
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT >= 2");
    end

    state_t           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_gidx;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [N_REQ-1:0] w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_g_valid;
    logic             w_g_last;
    logic             w_to_hit;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_valid  (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // r_grant is zero outside LOCK, so it alone gates the zero-latency datapath.
    assign w_g_valid = |(r_grant & req_valid);
    assign w_g_last  = |(r_grant & req_last);
    assign req_ready = r_grant & req_valid & {N_REQ{~tx_full}};
    assign wr_uart   = |req_ready;
    assign grant     = r_grant;
    assign busy      = (r_state == LOCK);

    // Route the granted requester's byte; zero whenever nothing is written.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) w_data = req_data[i*DATA_W +: DATA_W];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_abort;

    assign w_to_hit      = busy & ~w_g_valid & (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign timeout_abort = r_abort;

    // Count owner-idle LOCK cycles; tx_full stalls with valid high do not count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= w_to_hit;
            if ((r_state == IDLE) || wr_uart) begin
                r_to_cnt <= '0;
            end else if (!w_g_valid) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end
`else
    assign w_to_hit      = 1'b0;
    assign timeout_abort = 1'b0;
`endif

    // Arbitration FSM: grab a requester in IDLE, hold it until its last byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= IDX_W'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_state <= LOCK;
                    end
                end
                LOCK: begin
                    if ((wr_uart && w_g_last) || w_to_hit) begin
                        r_grant  <= '0;
                        r_rr_ptr <= r_gidx;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=3, TIMEOUT=16).
// A cycle table covers the single-requester datapath and tx_full stall;
// per-requester byte streams with a per-source scoreboard cover arbitration.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            wr_uart;
    logic [DW-1:0]   w_data;
    logic            tx_full;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_abort;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .wr_uart       (wr_uart),
        .w_data        (w_data),
        .tx_full       (tx_full),
        .grant         (grant),
        .busy          (busy),
        .timeout_abort (timeout_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       l;
        logic       tf;
        logic [7:0] d;
        logic [2:0] e_ready;
        logic       e_wr;
        logic [7:0] e_wd;
        logic [2:0] e_grant;
        logic       e_busy;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] src_q [N][$];
    logic [7:0] exp_q [N][$];
    int         grant_log [$];
    logic [N-1:0] en;
    logic [N-1:0] prev_grant;
    logic       s_busy;
    logic       s_abort;
    int         abort_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic enqueue(input int r, input logic [7:0] b, input logic last);
        src_q[r].push_back({last, b});
        exp_q[r].push_back(b);
    endtask

    // One clock: observe at negedge (scoreboard), then drive streams at posedge+1.
    task automatic tick();
        logic [N-1:0] acc;
        logic [8:0]   f;
        int           src;
        @(negedge clk);
        check("grant_onehot0", 32'($onehot0(grant)), 1);
        if (wr_uart) begin
            check("no_write_when_full", 32'(tx_full), 0);
            src = oh_idx(grant);
            if (exp_q[src].size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: req%0d wrote 0x%0h, expected no byte", src, w_data);
            end else begin
                check("sb_data", 32'(w_data), 32'(exp_q[src].pop_front()));
            end
        end
        if ((grant != '0) && (prev_grant == '0)) grant_log.push_back(oh_idx(grant));
        prev_grant = grant;
        s_busy     = busy;
        s_abort    = timeout_abort;
        if (timeout_abort) abort_cnt++;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
            if (en[i] && (src_q[i].size() > 0)) begin
                f = src_q[i][0];
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = f[7:0];
                req_last[i]           = f[8];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        int c;
        c = 0;
        while (((src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0 || busy) && (c < max_cycles)) begin
            tick();
            c++;
        end
        check(name, 32'(c < max_cycles), 1);
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        en        = '0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        grant_log.delete();
        prev_grant = '0;
        abort_cnt  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_abort", 32'(timeout_abort), 0);
        check("rst_wr", 32'(wr_uart), 0);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [14];
        int   c;

        // ---- Test 1 + 3: single requester datapath and tx_full stall (table) ----
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h55, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h55, 3'b001, 1'b1, 8'h55, 3'b001, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hAA, 3'b001, 1'b1, 8'hAA, 3'b001, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hF0, 3'b001, 1'b1, 8'hF0, 3'b001, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h11, 3'b001, 1'b1, 8'h11, 3'b001, 1'b1};
        for (int k = 7; k <= 11; k++)
            vecs[k] = '{1'b1, 1'b1, 1'b1, 8'h22, 3'b000, 1'b0, 8'h00, 3'b001, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h22, 3'b001, 1'b1, 8'h22, 3'b001, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0};

        reset_dut();
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            req_valid = {2'b00, vecs[k].v};
            req_last  = {2'b00, vecs[k].l};
            req_data  = {16'h0000, vecs[k].d};
            tx_full   = vecs[k].tf;
            #1;
            check($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(vecs[k].e_ready));
            check($sformatf("tbl%0d_wr", k), 32'(wr_uart), 32'(vecs[k].e_wr));
            check($sformatf("tbl%0d_wdata", k), 32'(w_data), 32'(vecs[k].e_wd));
            check($sformatf("tbl%0d_grant", k), 32'(grant), 32'(vecs[k].e_grant));
            check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
        end

        // ---- Test 2: two contenders, whole packets, round-robin ----
        reset_dut();
        enqueue(0, 8'hA0, 1'b0); enqueue(0, 8'hA1, 1'b1);
        enqueue(1, 8'hB0, 1'b0); enqueue(1, 8'hB1, 1'b1);
        en = 3'b011;
        drain("t2a_drain", 100);
        enqueue(0, 8'hA2, 1'b0); enqueue(0, 8'hA3, 1'b1);
        enqueue(1, 8'hB2, 1'b0); enqueue(1, 8'hB3, 1'b1);
        drain("t2b_drain", 100);
        check("t2_npkts", 32'(grant_log.size()), 4);
        if (grant_log.size() == 4) begin
            check("t2_order0", 32'(grant_log[0]), 0);
            check("t2_order1", 32'(grant_log[1]), 1);
            check("t2_order2", 32'(grant_log[2]), 0);
            check("t2_order3", 32'(grant_log[3]), 1);
        end

        // ---- Test 4: reset mid-packet ----
        reset_dut();
        enqueue(0, 8'hC0, 1'b0); enqueue(0, 8'hC1, 1'b0); enqueue(0, 8'hC2, 1'b1);
        en = 3'b001;
        c = 0;
        while ((src_q[0].size() != 1) && (c < 20)) begin
            tick();
            c++;
        end
        check("t4_reach_mid", 32'(c < 20), 1);
        #1;
        check("t4_pre_wr", 32'(wr_uart), 1);
        reset = 1'b0;
        #1;
        check("t4_rst_grant", 32'(grant), 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_wr", 32'(wr_uart), 0);
        check("t4_rst_ready", 32'(req_ready), 0);
        src_q[0].delete();
        exp_q[0].delete();
        req_valid = '0;
        req_last  = '0;
        en        = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        prev_grant = '0;
        grant_log.delete();
        enqueue(1, 8'hD1, 1'b1);
        enqueue(0, 8'hD0, 1'b1);
        en = 3'b011;
        drain("t4_drain", 100);
        check("t4_npkts", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("t4_first", 32'(grant_log[0]), 0);
            check("t4_second", 32'(grant_log[1]), 1);
        end

        // ---- Test 5: owner drops valid mid-packet ----
        reset_dut();
        enqueue(0, 8'hE0, 1'b0);
        enqueue(1, 8'hF1, 1'b1);
        en = 3'b011;
        c = 0;
        while ((src_q[0].size() != 0) && (c < 20)) begin
            tick();
            c++;
        end
        check("t5_first_byte", 32'(c < 20), 1);
`ifdef UART_ARB_TIMEOUT_EN
        c = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (s_abort) begin
                c = k;
                break;
            end
            check("t5_lock_held", 32'(s_busy), 1);
        end
        check("t5_abort_cycle", 32'(c), TO + 1);
        check("t5_abort_idle", 32'(s_busy), 0);
        tick();
        check("t5_abort_pulse", 32'(s_abort), 0);
        drain("t5_drain", 100);
        check("t5_abort_count", 32'(abort_cnt), 1);
`else
        for (int k = 0; k < 40; k++) begin
            tick();
            check("t5_lock_held", 32'(s_busy), 1);
        end
        check("t5_grant_held", 32'(grant), 32'(3'b001));
        enqueue(0, 8'hE1, 1'b1);
        drain("t5_drain", 100);
        check("t5_abort_count", 32'(abort_cnt), 0);
`endif
        check("t5_npkts", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            check("t5_first", 32'(grant_log[0]), 0);
            check("t5_second", 32'(grant_log[1]), 1);
        end

        // ---- Test 6: three requesters, 1-byte packets ----
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < N; r++) enqueue(r, 8'((r << 4) | p), 1'b1);
        end
        en = 3'b111;
        drain("t6_drain", 100);
        check("t6_npkts", 32'(grant_log.size()), 6);
        if (grant_log.size() == 6) begin
            for (int k = 0; k < 6; k++) check($sformatf("t6_order%0d", k), 32'(grant_log[k]), 32'(k % N));
        end

        check("sb_all_consumed", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
